// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states and frame-length constants,
// also used by SPI_RX and SPI_mstr.
package spi_pkg;

  typedef enum logic {IDLE, SHIFT} spi_slv_state_t;

  localparam logic [4:0] LEN8  = 5'd8;
  localparam logic [4:0] LEN16 = 5'd16;

  function automatic logic [4:0] frame_len(input logic len8_16);
    return len8_16 ? LEN8 : LEN16;
  endfunction

endpackage

// File: rtl/spi_slv_tx_if.sv
// Host-side handshake of the SPI slave responder: word load, status pulses
// and the captured MOSI word.
interface spi_slv_tx_if;
  import spi_pkg::*;

  logic [15:0] tx_data;
  logic        wrt;
  logic        tx_full;
  logic        done;
  logic        abort;
  logic        underrun;
  logic [15:0] rx_data;

  modport slave (
    input  tx_data, wrt,
    output tx_full, done, abort, underrun, rx_data
  );

  modport master (
    output tx_data, wrt,
    input  tx_full, done, abort, underrun, rx_data
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous input, with one extra flop giving
// single-cycle rise/fall pulses. All flops preset to RST_VAL on reset.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_slv_tx.sv
// SPI slave responder: shifts one buffered host word out on MISO, MSB first.
// MOSI capture and rx_data exist only when SPI_SLV_FULL_DUPLEX_EN is defined.
import spi_pkg::*;

module spi_slv_tx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              edg,
  input  logic              len8_16,
  output logic              MISO,
  output logic              MISO_oe,
  spi_slv_tx_if.slave       host
);

  spi_slv_state_t state_q, state_d;

  logic        ss_sync, ss_rise, ss_fall;
  logic        unused_sclk_lvl, sclk_rise, sclk_fall;
  logic        sample_edge, launch_edge;
  logic        start, finish;
  logic [15:0] buf_q, shreg_q;
  logic        full_q;
  logic [4:0]  cnt_q;
  logic        len_q;
  logic        cnt_full;
  logic        done_q, abort_q, underrun_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .async_in(SS_n),
    .sync_out(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .async_in(SCLK),
    .sync_out(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  assign sample_edge = edg ? sclk_rise : sclk_fall;
  assign launch_edge = edg ? sclk_fall : sclk_rise;
  assign cnt_full    = (cnt_q == frame_len(len_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (ss_fall) begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (ss_rise) begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A wrt coinciding with frame start still sets tx_full: the frame takes the
  // old buffer (or underruns) while the new word stays queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      len_q      <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;

      if (host.wrt) begin
        buf_q  <= host.tx_data;
        full_q <= 1'b1;
      end else if (start) begin
        full_q <= 1'b0;
      end

      if (start) begin
        len_q      <= len8_16;
        cnt_q      <= '0;
        underrun_q <= ~full_q;
        if (!full_q)      shreg_q <= '0;
        else if (len8_16) shreg_q <= {buf_q[7:0], 8'h00};
        else              shreg_q <= buf_q;
      end else if (state_q == SHIFT && !finish && !cnt_full) begin
        if (sample_edge) cnt_q   <= cnt_q + 5'd1;
        if (launch_edge) shreg_q <= {shreg_q[14:0], 1'b0};
      end

      if (finish) begin
        done_q  <= cnt_full;
        abort_q <= ~cnt_full;
      end
    end
  end

`ifdef SPI_SLV_FULL_DUPLEX_EN
  logic        mosi_sync;
  logic        unused_mosi_rise, unused_mosi_fall;
  logic [15:0] cap_q, rx_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .async_in(MOSI),
    .sync_out(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      rx_q  <= '0;
    end else begin
      if (start)
        cap_q <= '0;
      else if (state_q == SHIFT && !finish && !cnt_full && sample_edge)
        cap_q <= {cap_q[14:0], mosi_sync};
      if (finish && cnt_full)
        rx_q <= len_q ? {8'h00, cap_q[7:0]} : cap_q;
    end
  end

  assign host.rx_data = rx_q;
`else
  logic unused_mosi;
  assign unused_mosi  = MOSI;
  assign host.rx_data = '0;
`endif

  assign MISO          = (state_q == SHIFT) & shreg_q[15];
  assign MISO_oe       = ~ss_sync;
  assign host.tx_full  = full_q;
  assign host.done     = done_q;
  assign host.abort    = abort_q;
  assign host.underrun = underrun_q;

endmodule

// File: tb/tb_spi_slv_tx.sv
// Bench for spi_slv_tx: a bit-level SPI master drives frames and a word-level
// model of the host buffer predicts MISO bits, rx_data and status pulses.
module tb_spi_slv_tx;

  localparam int unsigned STG  = 2;
  localparam int unsigned HALF = STG + 4;

  logic clk = 1'b0;
  logic rst, SS_n, SCLK, MOSI, edg, len8_16;
  logic MISO, MISO_oe;

  spi_slv_tx_if host ();

  spi_slv_tx #(.SYNC_STAGES(STG)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .edg(edg), .len8_16(len8_16), .MISO(MISO), .MISO_oe(MISO_oe),
    .host(host)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_done = 0, n_abort = 0, n_under = 0;

  logic [15:0] m_buf = '0;
  bit          m_full = 1'b0;
  logic [15:0] m_rx = '0;

  always @(negedge clk) begin
    if (host.done === 1'b1)     n_done++;
    if (host.abort === 1'b1)    n_abort++;
    if (host.underrun === 1'b1) n_under++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [15:0] w);
    @(negedge clk);
    host.tx_data = w;
    host.wrt     = 1'b1;
    @(negedge clk);
    host.wrt = 1'b0;
    m_buf  = w;
    m_full = 1'b1;
    check("tx_full_set", host.tx_full, 1);
  endtask

  task automatic run_frame(input string tag, input int nbits, input bit e, input bit l8,
                           input logic [15:0] mosi_w, input bit mid_wrt,
                           input logic [15:0] mid_w, input bit do_rst);
    int flen, d0, a0, u0, lat;
    bit full, exp_under;
    logic [15:0] got, exp_tx, mask, exp_rx;
    flen      = l8 ? 8 : 16;
    full      = (nbits == flen);
    got       = '0;
    exp_under = !m_full;
    exp_tx    = !m_full ? 16'h0000 : (l8 ? {m_buf[7:0], 8'h00} : m_buf);
    m_full    = 1'b0;

    @(negedge clk);
    edg = e; len8_16 = l8; SCLK = ~e; MOSI = mosi_w[flen-1];
    wait_clk(HALF);
    d0 = n_done; a0 = n_abort; u0 = n_under;
    SS_n = 1'b0;
    wait_clk(HALF);
    check({tag, "_oe_on"}, MISO_oe, 1);

    for (int i = 0; i < nbits; i++) begin
      got[15-i] = MISO;
      SCLK = e;
      wait_clk(HALF);
      SCLK = ~e;
      if (i + 1 < flen) MOSI = mosi_w[flen-2-i];
      if (mid_wrt && i == 2) begin
        host.tx_data = mid_w;
        host.wrt     = 1'b1;
        wait_clk(1);
        host.wrt = 1'b0;
        m_buf  = mid_w;
        m_full = 1'b1;
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
    end

    if (do_rst) begin
      rst = 1'b1; SS_n = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      m_buf = '0; m_full = 1'b0; m_rx = '0;
      wait_clk(3*STG + 6);
      check({tag, "_done_cnt"},  n_done - d0,  0);
      check({tag, "_abort_cnt"}, n_abort - a0, 0);
    end else begin
      SS_n = 1'b1;
      lat  = 0;
      for (int k = 1; k <= 3*STG + 6; k++) begin
        @(negedge clk);
        if (lat == 0 && (host.done === 1'b1 || host.abort === 1'b1)) lat = k;
      end
      check({tag, "_latency"},   lat, STG + 1);
      check({tag, "_done_cnt"},  n_done - d0,  full ? 1 : 0);
      check({tag, "_abort_cnt"}, n_abort - a0, full ? 0 : 1);
      if (full) m_rx = l8 ? {8'h00, mosi_w[7:0]} : mosi_w;
    end

    mask = ~(16'hFFFF >> nbits);
    check({tag, "_miso"},    got & mask, exp_tx & mask);
    check({tag, "_underrun"}, n_under - u0, exp_under ? 1 : 0);
    check({tag, "_tx_full"}, host.tx_full, m_full);
    check({tag, "_oe_off"},  MISO_oe, 0);
`ifdef SPI_SLV_FULL_DUPLEX_EN
    exp_rx = m_rx;
`else
    exp_rx = 16'h0000;
`endif
    check({tag, "_rx_data"}, host.rx_data, exp_rx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; edg = 1'b1; len8_16 = 1'b0;
    host.tx_data = '0; host.wrt = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check("rst_miso",     MISO, 0);
    check("rst_miso_oe",  MISO_oe, 0);
    check("rst_tx_full",  host.tx_full, 0);
    check("rst_done",     host.done, 0);
    check("rst_abort",    host.abort, 0);
    check("rst_underrun", host.underrun, 0);
    check("rst_rx_data",  host.rx_data, 0);

    host_write(16'h8123);
    run_frame("f16_e1", 16, 1'b1, 1'b0, 16'hA5C3, 1'b0, 16'h0, 1'b0);

    host_write(16'h0123);
    run_frame("f8_e0", 8, 1'b0, 1'b1, 16'h005A, 1'b0, 16'h0, 1'b0);

    run_frame("underrun", 16, 1'b1, 1'b0, 16'h3C3C, 1'b0, 16'h0, 1'b0);

    host_write(16'hF00F);
    run_frame("short", 5, 1'b1, 1'b0, 16'hFFFF, 1'b1, 16'hC0DE, 1'b0);
    run_frame("after_short", 16, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0, 1'b0);

    host_write(16'hBEEF);
    run_frame("rst_mid", 7, 1'b1, 1'b0, 16'h7777, 1'b0, 16'h0, 1'b1);
    host_write(16'h1111);
    run_frame("after_rst", 16, 1'b1, 1'b0, 16'h2468, 1'b0, 16'h0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      bit e, l8;
      logic [15:0] tw, mw;
      e  = 1'($urandom_range(1, 0));
      l8 = 1'($urandom_range(1, 0));
      tw = 16'($urandom);
      mw = 16'($urandom);
      if ($urandom_range(3, 0) != 0) host_write(tw);
      run_frame($sformatf("rnd%0d", r), l8 ? 8 : 16, e, l8, mw, 1'b0, 16'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
